// File: rtl/mem_req_arbiter_rr.sv
// N-requester memory request arbiter: round-robin or fixed-priority grant, per-requester
// credit tracking, a one-entry registered slot toward the router and tag-routed responses.
module mem_req_arbiter_rr #(
   parameter int NUM_REQ  = 5,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 64,
   parameter int MAX_OUT  = 4,
   parameter int ARB_MODE = 0,
   parameter int TAG_W    = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rtr_req_valid,
   input  logic                        rtr_req_ready,
   output logic                        rtr_req_we,
   output logic [ADDR_W-1:0]           rtr_req_addr,
   output logic [DATA_W-1:0]           rtr_req_wdata,
   output logic [TAG_W-1:0]            rtr_req_tag,
   input  logic                        rtr_rsp_valid,
   output logic                        rtr_rsp_ready,
   input  logic [TAG_W-1:0]            rtr_rsp_tag,
   input  logic [DATA_W-1:0]           rtr_rsp_data,
   output logic                        busy,
   output logic                        err_bad_tag
);
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [TAG_W-1:0] PTR_RST = TAG_W'(NUM_REQ - 1);

   logic [NUM_REQ-1:0] elig_s, grant_s, issue_s, ret_s, rsp_valid_s;
   logic               load_s, has_grant_s, tag_ok_s, rsp_sel_ready_s, busy_s;
   logic [TAG_W-1:0]   win_s;
   logic [CNT_W-1:0]   outst_q [NUM_REQ];
   logic [CNT_W-1:0]   outst_d [NUM_REQ];
   logic [TAG_W-1:0]   ptr_q, ptr_d;
   logic               slot_valid_q, slot_valid_d;
   logic               slot_we_q, slot_we_d;
   logic [ADDR_W-1:0]  slot_addr_q, slot_addr_d;
   logic [DATA_W-1:0]  slot_wdata_q, slot_wdata_d;
   logic [TAG_W-1:0]   slot_tag_q, slot_tag_d;
   logic               err_q, err_d;

   // Eligibility (credit available) and one-hot grant search
   always_comb begin
      int idx;
      idx         = 0;
      elig_s      = '0;
      grant_s     = '0;
      win_s       = '0;
      has_grant_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig_s[i] = req_valid[i] && (outst_q[i] < MAX_CNT);
      end
      // RR starts one past the last winner; fixed mode simply scans from index 0
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (ARB_MODE == 1) begin
            idx = k - 1;
         end else begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
         end
         if (!has_grant_s && elig_s[idx]) begin
            grant_s[idx] = 1'b1;
            win_s        = TAG_W'(idx);
            has_grant_s  = 1'b1;
         end else begin
            win_s = win_s;
         end
      end
   end

   assign load_s    = !slot_valid_q || rtr_req_ready;
   assign issue_s   = (load_s && has_grant_s) ? grant_s : '0;
   assign req_ready = issue_s;

   // Output slot and round-robin pointer next state
   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_we_d    = slot_we_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      slot_tag_d   = slot_tag_q;
      ptr_d        = ptr_q;
      if (load_s) begin
         slot_valid_d = has_grant_s;
         if (has_grant_s) begin
            slot_we_d    = req_we[win_s];
            slot_addr_d  = req_addr[int'(win_s)*ADDR_W +: ADDR_W];
            slot_wdata_d = req_wdata[int'(win_s)*DATA_W +: DATA_W];
            slot_tag_d   = win_s;
            ptr_d        = (ARB_MODE == 0) ? win_s : ptr_q;
         end else begin
            ptr_d = ptr_q;
         end
      end else begin
         slot_valid_d = slot_valid_q;
      end
   end

   // Response steering by tag; out-of-range tags are accepted and dropped
   always_comb begin
      rsp_valid_s     = '0;
      rsp_sel_ready_s = 1'b0;
      tag_ok_s        = (int'(rtr_rsp_tag) < NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(rtr_rsp_tag) == i) begin
            rsp_valid_s[i]  = rtr_rsp_valid;
            rsp_sel_ready_s = rsp_ready[i];
         end else begin
            rsp_valid_s[i] = 1'b0;
         end
      end
      err_d = err_q || (rtr_rsp_valid && !tag_ok_s);
   end

   assign ret_s         = rsp_valid_s & rsp_ready;
   assign rsp_valid     = rsp_valid_s;
   assign rtr_rsp_ready = tag_ok_s ? rsp_sel_ready_s : 1'b1;
   assign rsp_data      = rtr_rsp_data;

   // Saturating outstanding-credit counters and busy summary
   always_comb begin
      busy_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         outst_d[i] = outst_q[i];
         if (issue_s[i] && !ret_s[i]) begin
            if (outst_q[i] != MAX_CNT) begin
               outst_d[i] = outst_q[i] + CNT_ONE;
            end else begin
               outst_d[i] = outst_q[i];
            end
         end else if (ret_s[i] && !issue_s[i]) begin
            if (outst_q[i] != '0) begin
               outst_d[i] = outst_q[i] - CNT_ONE;
            end else begin
               outst_d[i] = outst_q[i];
            end
         end else begin
            outst_d[i] = outst_q[i];
         end
         busy_s = busy_s || (outst_q[i] != '0);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid_q <= 1'b0;
         slot_we_q    <= 1'b0;
         slot_addr_q  <= '0;
         slot_wdata_q <= '0;
         slot_tag_q   <= '0;
         ptr_q        <= PTR_RST;
         err_q        <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            outst_q[i] <= '0;
         end
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_we_q    <= slot_we_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         slot_tag_q   <= slot_tag_d;
         ptr_q        <= ptr_d;
         err_q        <= err_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            outst_q[i] <= outst_d[i];
         end
      end
   end

   assign rtr_req_valid = slot_valid_q;
   assign rtr_req_we    = slot_we_q;
   assign rtr_req_addr  = slot_addr_q;
   assign rtr_req_wdata = slot_wdata_q;
   assign rtr_req_tag   = slot_tag_q;
   assign busy          = busy_s;
   assign err_bad_tag   = err_q;
endmodule
